// File: rtl/pool_engine_pkg.sv
// pool_engine_pkg: state encoding, fp16 ordering key and default widths shared by pool_engine
package pool_engine_pkg;
    localparam int LANES_DEF  = 8;
    localparam int DATA_W_DEF = 16;
    localparam int BURST_LEN  = 1;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_e;
    // unsigned order of the key matches numeric fp16 order, with -0 just below +0
    function automatic logic [15:0] fp16_key(input logic [15:0] x);
        return x[15] ? ~x : x | 16'h8000;
    endfunction
endpackage

// File: rtl/pool_engine_if.sv
// pool_engine_if: configuration, data RAM read port and pooled result stream of pool_engine
interface pool_engine_if
    import pool_engine_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = 10
);
    logic                    start;
    logic [3:0]              kernel;
    logic [3:0]              stride;
    logic [7:0]              i_side;
    logic [7:0]              o_side;
    logic [7:0]              groups;
    logic                    rd_en;
    logic [ADDR_W-1:0]       rd_addr;
    logic [LANES*DATA_W-1:0] rd_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_data;
    logic                    busy;
    logic                    finish;
    modport slave (
        input  start, kernel, stride, i_side, o_side, groups, rd_data, out_ready,
        output rd_en, rd_addr, out_valid, out_data, busy, finish
    );
    modport master (
        output start, kernel, stride, i_side, o_side, groups, rd_data, out_ready,
        input  rd_en, rd_addr, out_valid, out_data, busy, finish
    );
endinterface

// File: rtl/pool_ofifo.sv
// pool_ofifo: LANES-wide result buffer with occupancy count and same-cycle push/pop
module pool_ofifo #(
    parameter int W     = 128,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             data_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wp_q] <= data_i;
                wp_q        <= wp_q + 1'b1;
            end
            if (pop_i) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    assign data_o  = mem_q[rp_q];
    assign count_o = cnt_q;
endmodule

// File: rtl/pool_engine.sv
// pool_engine: k x k fp16 max-pool walker, per-lane reducers and lane serializer.
// POOL_PERF_EN adds cyc_count / stall_count performance counters.
module pool_engine
    import pool_engine_pkg::*;
#(
    parameter int LANES       = LANES_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = 10,
    parameter int OFIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    pool_engine_if.slave bus
`ifdef POOL_PERF_EN
    ,
    output logic [31:0]  cyc_count,
    output logic [31:0]  stall_count
`endif
);
    localparam int CW = $clog2(OFIFO_DEPTH) + 1;
    localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
    localparam int W  = LANES * DATA_W;

    state_e            st_q, st_d;
    logic [3:0]        k_q, s_q, kx_q, kx_d, ky_q, ky_d;
    logic [7:0]        is_q, os_q, gn_q, ox_q, ox_d, oy_q, oy_d, g_q, g_d;
    logic [ADDR_W-1:0] sq_q, sis_q, gb_q, gb_d, rb_q, rb_d, cb_q, cb_d, kr_q, kr_d;
    logic              pend_q, first_q, last_q;
    logic [LW-1:0]     lane_q;
    logic [W-1:0]      win, head;
    logic [CW-1:0]     cnt;
    logic              go, deg, lkx, lky, lox, loy, lg, wfirst, rd, last_rd;
    logic              push, acc, pop, drained, busy;

    // i_side^2 and stride*i_side are formed once at start by shift-add, so the walker only adds
    function automatic logic [ADDR_W-1:0] smul(input logic [7:0] a, input logic [7:0] b);
        logic [ADDR_W-1:0] r = '0;
        for (int i = 0; i < 8; i++) r = a[i] ? r + (ADDR_W'(b) << i) : r;
        return r;
    endfunction

    assign go      = st_q == IDLE && bus.start;
    assign deg     = k_q == 4'd0 || os_q == 8'd0 || gn_q == 8'd0;
    assign lkx     = kx_q == k_q - 4'd1;
    assign lky     = ky_q == k_q - 4'd1;
    assign lox     = ox_q == os_q - 8'd1;
    assign loy     = oy_q == os_q - 8'd1;
    assign lg      = g_q == gn_q - 8'd1;
    assign wfirst  = kx_q == 4'd0 && ky_q == 4'd0;
    assign rd      = st_q == RUN && !deg && (!wfirst || cnt <= CW'(OFIFO_DEPTH - 2));
    assign last_rd = rd && lkx && lky && lox && loy && lg;
    assign push    = pend_q && last_q;
    assign acc     = bus.out_valid && bus.out_ready;
    assign pop     = acc && lane_q == LW'(LANES - 1);
    assign drained = !pend_q && (cnt == '0 || (cnt == CW'(1) && pop));
    assign busy    = st_q == RUN || st_q == DRAIN;

    always_comb begin
        kx_d = kx_q;
        ky_d = ky_q;
        ox_d = ox_q;
        oy_d = oy_q;
        g_d  = g_q;
        gb_d = gb_q;
        rb_d = rb_q;
        cb_d = cb_q;
        kr_d = kr_q;
        if (rd) begin
            kx_d = lkx ? 4'd0 : kx_q + 4'd1;
            if (lkx) begin
                ky_d = lky ? 4'd0 : ky_q + 4'd1;
                kr_d = kr_q + ADDR_W'(is_q);
                if (lky) begin
                    ox_d = lox ? 8'd0 : ox_q + 8'd1;
                    cb_d = cb_q + ADDR_W'(s_q);
                    kr_d = cb_d;
                    if (lox) begin
                        oy_d = loy ? 8'd0 : oy_q + 8'd1;
                        rb_d = rb_q + sis_q;
                        cb_d = rb_d;
                        kr_d = rb_d;
                        if (loy) begin
                            g_d  = g_q + 8'd1;
                            gb_d = gb_q + sq_q;
                            rb_d = gb_d;
                            cb_d = gb_d;
                            kr_d = gb_d;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            IDLE:    st_d = go ? RUN : IDLE;
            RUN:     st_d = deg ? DONE : last_rd ? DRAIN : RUN;
            DRAIN:   st_d = drained ? DONE : DRAIN;
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            st_q    <= IDLE;
            k_q     <= '0;
            s_q     <= '0;
            is_q    <= '0;
            os_q    <= '0;
            gn_q    <= '0;
            sq_q    <= '0;
            sis_q   <= '0;
            kx_q    <= '0;
            ky_q    <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            g_q     <= '0;
            gb_q    <= '0;
            rb_q    <= '0;
            cb_q    <= '0;
            kr_q    <= '0;
            pend_q  <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            lane_q  <= '0;
        end else begin
            st_q    <= st_d;
            pend_q  <= rd;
            first_q <= rd && wfirst;
            last_q  <= rd && lkx && lky;
            if (acc) lane_q <= pop ? '0 : lane_q + 1'b1;
            if (go) begin
                k_q   <= bus.kernel;
                s_q   <= bus.stride;
                is_q  <= bus.i_side;
                os_q  <= bus.o_side;
                gn_q  <= bus.groups;
                sq_q  <= smul(bus.i_side, bus.i_side);
                sis_q <= smul({4'd0, bus.stride}, bus.i_side);
                kx_q  <= '0;
                ky_q  <= '0;
                ox_q  <= '0;
                oy_q  <= '0;
                g_q   <= '0;
                gb_q  <= '0;
                rb_q  <= '0;
                cb_q  <= '0;
                kr_q  <= '0;
            end else begin
                kx_q  <= kx_d;
                ky_q  <= ky_d;
                ox_q  <= ox_d;
                oy_q  <= oy_d;
                g_q   <= g_d;
                gb_q  <= gb_d;
                rb_q  <= rb_d;
                cb_q  <= cb_d;
                kr_q  <= kr_d;
            end
        end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [DATA_W-1:0] x, mx_q;
        assign x = bus.rd_data[l*DATA_W +: DATA_W];
        assign win[l*DATA_W +: DATA_W] = first_q || fp16_key(x) > fp16_key(mx_q) ? x : mx_q;
        always_ff @(posedge clk or posedge rst)
            if (rst) mx_q <= '0;
            else if (pend_q) mx_q <= win[l*DATA_W +: DATA_W];
    end

    pool_ofifo #(.W(W), .DEPTH(OFIFO_DEPTH)) u_ofifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .data_i (win),
        .pop_i  (pop),
        .data_o (head),
        .count_o(cnt)
    );

    assign bus.rd_en     = rd;
    assign bus.rd_addr   = rd ? kr_q + ADDR_W'(kx_q) : '0;
    assign bus.out_valid = cnt != '0;
    assign bus.out_data  = bus.out_valid ? head[lane_q*DATA_W +: DATA_W] : '0;
    assign bus.busy      = busy;
    assign bus.finish    = st_q == DONE;

`ifdef POOL_PERF_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cyc_count   <= '0;
            stall_count <= '0;
        end else if (go) begin
            cyc_count   <= '0;
            stall_count <= '0;
        end else begin
            if (busy) cyc_count <= cyc_count + 32'd1;
            if (st_q == RUN && !rd) stall_count <= stall_count + 32'd1;
        end
`endif
endmodule

// File: doc/pool_engine.md
# pool_engine

Parametrised max-pooling engine, next generation of the engine's pooling datapath. Walks a full 2-D k×k window over an i_side×i_side feature map for any number of LANES-wide channel groups. Reads the data RAM one word per cycle and reduces each window per lane with an fp16 max. Results go into an internal output buffer, and a serializer drains it lane by lane under valid/ready backpressure; the read side stalls instead of dropping results.

## Interface
- LANES, 8: channels per RAM word / parallel compare lanes.
- DATA_W, 16: lane width (fp16).
- ADDR_W, 10: data RAM word-address width.
- OFIFO_DEPTH, 4: output buffer depth in LANES-wide entries (power of 2, ≥2).
- clk  in  1  clock; one clock domain.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; latches config when idle, ignored while busy.
- kernel  in  4  window side k.
- stride  in  4  window step s.
- i_side  in  8  input map side.
- o_side  in  8  output map side.
- groups  in  8  number of channel groups (ceil(channels/LANES)).
- rd_en  out  1  data RAM read strobe.
- rd_addr  out  ADDR_W  data RAM word address.
- rd_data  in  LANES*DATA_W  RAM word; valid exactly 1 cycle after rd_en; lane i at [i*DATA_W +: DATA_W].
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts out_data.
- out_data  out  DATA_W  one pooled lane value.
- busy  out  1  high from the cycle after accepted start until finish.
- finish  out  1  one-cycle pulse when all results have been accepted.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 latches kernel/stride/i_side/o_side/groups and moves to RUN.
- Degenerate config (kernel, o_side or groups == 0): RUN→DONE next cycle. No reads, no outputs.
- Loop order, outer to inner: group g, oy, ox, ky, kx.
- rd_addr = g*i_side² + (oy*s+ky)*i_side + (ox*s+kx), truncated to ADDR_W.
  - Computed incrementally with base registers and adders; no multipliers.
  - Caller guarantees it fits.
- One read per cycle in RUN unless stalled.
- A window issues its first read only if the output buffer has ≥2 free entries (current occupancy plus one in-flight window). Mid-window reads never stall.
- Per lane, fp16 max uses a key compare:
  - key = x[15] ? ~x : x|16'h8000, compared unsigned.
  - The running max loads on the window's first element.
  - −0 < +0; NaN is not special-cased.
- On the last element of a window the LANES results are pushed as one buffer entry.
- After the last read of the last window: RUN→DRAIN.
- DRAIN→DONE when the buffer is empty, no window is in flight, and the last lane has been accepted.
- DONE: finish=1 for one cycle, then IDLE.
- Serializer:
  - out_valid=1 whenever the buffer is non-empty.
  - out_data = head-entry lane `lane_idx`, lane 0 first.
  - lane_idx advances on out_valid & out_ready; the entry pops on acceptance of lane LANES-1.
  - out_data is stable while out_valid & !out_ready.
- A push and a pop in the same cycle are both performed; occupancy is unchanged.
- rst mid-operation clears all state, buffer contents and counters; the in-flight read is discarded.

## Timing
- Reset values: rd_en=0, rd_addr=0, out_valid=0, out_data=0, busy=0, finish=0, state IDLE.
- First rd_en: the cycle after the start pulse.
- Window without stall: k² consecutive rd_en cycles.
- First out_valid of a window: first rd_en cycle + k² + 1.
- Throughput: one window per max(k², LANES) cycles when out_ready=1 and OFIFO_DEPTH ≥2.
- finish: the cycle after the last lane is accepted.
- busy falls together with finish.

## Configuration
- POOL_PERF_EN defined: adds outputs cyc_count (32), counting cycles while busy, and stall_count (32), counting RUN cycles with rd_en=0.
  - Both clear on accepted start; both reset to 0.
- POOL_PERF_EN undefined: these ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package holds:
  - State encoding constants (IDLE=0, RUN=1, DRAIN=2, DONE=3).
  - The fp16 ordered-key function.
  - The LANES and DATA_W defaults, alongside BURST_LEN.
- One sub-module: pool_ofifo. It is a synchronous LANES*DATA_W-wide FIFO with OFIFO_DEPTH entries, count output, and simultaneous push/pop.
- The address walker, the compare lanes and the serializer stay in pool_engine.

## Test plan
- k=2, s=2, i_side=4, o_side=2, groups=1, RAM word n holds lane i = fp16(n+i), out_ready=1.
  - Expect 4 windows × 8 values.
  - Window 0 = fp16(5+i).
  - rd_addr sequence 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15.
  - Then finish pulse.
- Mixed signs: window values {0xC000, 0x8000, 0x0000, 0xBC00} → 0x0000; all-negative {0xC000, 0xBC00, 0xC200, 0xC400} → 0xBC00.
- k=3, s=1, i_side=5, o_side=3, groups=2: 18 windows.
  - Group 1 addresses are offset by 25.
  - 144 outputs; finish exactly once.
- out_ready held 0 for 200 cycles mid-run.
  - rd_en stops with ≤OFIFO_DEPTH entries buffered.
  - out_data stable; no value lost or duplicated after release.
- groups=0 → finish 2 cycles after start, no rd_en, no out_valid.
  - A start pulse while busy is ignored.
- rst pulse during RUN: all outputs return to reset values the same cycle.
  - A new start runs cleanly from address 0.
